lsu_dccm_ctl: RTL and testbench



---
 rtl/lsu_dccm_if.sv | 40 ++++
 rtl/lsu_dccm_ctl.sv | 106 ++++++++++
 tb/tb_lsu_dccm_ctl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_dccm_if.sv
// lsu_dccm_if: LSU request/response and DCCM read/write port bundle
interface lsu_dccm_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_store;
  logic                        req_unsigned;
  logic [1:0]                  req_size;
  logic [DCCM_BITS-1:0]        req_addr;
  logic [31:0]                 req_wdata;
  logic                        rsp_valid;
  logic                        rsp_err;
  logic [31:0]                 rsp_rdata;
  logic                        dccm_rden;
  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi;
  modport slave (
    input  req_valid, req_store, req_unsigned, req_size, req_addr, req_wdata,
           dccm_rd_data_lo, dccm_rd_data_hi,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, dccm_rden, dccm_wren,
           dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi,
           dccm_wr_data_lo, dccm_wr_data_hi
  );
  modport master (
    output req_valid, req_store, req_unsigned, req_size, req_addr, req_wdata,
           dccm_rd_data_lo, dccm_rd_data_hi,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, dccm_rden, dccm_wren,
           dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi,
           dccm_wr_data_lo, dccm_wr_data_hi
  );
endinterface

// File: rtl/lsu_dccm_ctl.sv
// lsu_dccm_ctl: DCCM initiator with misaligned split, RMW stores and load extraction
module lsu_dccm_ctl #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_BANK_BITS   = 2,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input logic       clk,
  input logic       rst,
  lsu_dccm_if.slave bus
);
  localparam int AW = DCCM_BITS;
  localparam int EW = DCCM_FDATA_WIDTH - 32;
  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, ERR} state_t;
  state_t state, state_nx;
  logic          st_q, uns_q;
  logic [1:0]    size_q;
  logic [AW-1:0] lo_q, hi_q, rd_lo_q, rd_hi_q, wr_lo_q, wr_hi_q;
  logic [31:0]   wdata_q, wd_lo_q, wd_hi_q, ld;
  logic [AW-1:0] req_hi;
  logic          accept, word_st, rmw;
  logic [4:0]    sh;
  logic [3:0]    smask;
  logic [7:0]    be;
  logic [63:0]   m, w, d, bm, mrg;
  logic          unused_ok;
  assign req_hi  = bus.req_addr + AW'({bus.req_size[1], |bus.req_size});
  assign accept  = bus.req_valid & (state == IDLE) & ~rst;
  assign word_st = bus.req_store & (bus.req_size == 2'd2) &
                   (req_hi[AW-1:2] == bus.req_addr[AW-1:2]);
  assign rmw     = (state == MERGE) & st_q;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state == RD     ? MERGE :
               state != IDLE   ? IDLE  :
               !accept         ? IDLE  :
               &bus.req_size   ? ERR   :
               word_st         ? WR    : RD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {st_q, uns_q, size_q, lo_q, hi_q, wdata_q} <= '0;
      {rd_lo_q, rd_hi_q, wr_lo_q, wr_hi_q, wd_lo_q, wd_hi_q} <= '0;
    end else begin
      if (accept) begin
        st_q    <= bus.req_store;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        lo_q    <= bus.req_addr;
        hi_q    <= req_hi;
        wdata_q <= bus.req_wdata;
      end
      if (accept && !(&bus.req_size) && !word_st) begin
        rd_lo_q <= bus.req_addr;
        rd_hi_q <= req_hi;
      end
      if (accept && word_st) begin
        wr_lo_q <= bus.req_addr;
        wr_hi_q <= req_hi;
        wd_lo_q <= bus.req_wdata;
        wd_hi_q <= bus.req_wdata;
      end
      if (state == RD && st_q) begin
        wr_lo_q <= lo_q;
        wr_hi_q <= hi_q;
      end
      if (rmw) begin
        wd_lo_q <= mrg[31:0];
        wd_hi_q <= mrg[63:32];
      end
    end
  end
  // Both words are read even when aligned; lo==hi word then, so the 64-bit view stays consistent.
  always_comb begin
    sh    = {lo_q[1:0], 3'b000};
    m     = {bus.dccm_rd_data_hi[31:0], bus.dccm_rd_data_lo[31:0]};
    w     = m >> sh;
    smask = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
    be    = {4'b0000, smask} << lo_q[1:0];
    d     = {32'b0, wdata_q} << sh;
    bm    = '0;
    for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{be[i]}};
    mrg   = (m & ~bm) | (d & bm);
    ld    = size_q == 2'd0 ? {{24{~uns_q & w[7]}}, w[7:0]} :
            size_q == 2'd1 ? {{16{~uns_q & w[15]}}, w[15:0]} : w[31:0];
  end
  always_comb begin
    bus.req_ready       = state == IDLE;
    bus.rsp_valid       = ~rst & (state == ERR || state == WR || state == MERGE);
    bus.rsp_err         = ~rst & (state == ERR);
    bus.rsp_rdata       = (~rst & (state == MERGE) & ~st_q) ? ld : 32'b0;
    bus.dccm_rden       = ~rst & (state == RD);
    bus.dccm_wren       = ~rst & (state == WR || rmw);
    bus.dccm_rd_addr_lo = rd_lo_q;
    bus.dccm_rd_addr_hi = rd_hi_q;
    bus.dccm_wr_addr_lo = wr_lo_q;
    bus.dccm_wr_addr_hi = wr_hi_q;
    bus.dccm_wr_data_lo = {{EW{1'b0}}, rmw ? mrg[31:0] : wd_lo_q};
    bus.dccm_wr_data_hi = {{EW{1'b0}}, rmw ? mrg[63:32] : wd_hi_q};
  end
  assign unused_ok = ^{bus.dccm_rd_data_lo[DCCM_FDATA_WIDTH-1:32],
                       bus.dccm_rd_data_hi[DCCM_FDATA_WIDTH-1:32],
                       w[63:32], lo_q[2 +: DCCM_BANK_BITS]};
endmodule

// File: tb/tb_lsu_dccm_ctl.sv
// tb_lsu_dccm_ctl: directed vectors against hand-computed DCCM controller behaviour
module tb_lsu_dccm_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  lsu_dccm_if bus ();
  lsu_dccm_ctl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic st, input logic uns, input logic [1:0] sz,
                      input logic [15:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_unsigned = uns;
    bus.req_size     = sz;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    step();
    bus.req_valid    = 1'b0;
  endtask
  task automatic mem(input logic [31:0] lo, input logic [31:0] hi);
    bus.dccm_rd_data_lo = {7'h7f, lo};
    bus.dccm_rd_data_hi = {7'h7f, hi};
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.req_size = 2'd0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    mem(32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.dccm_rden, bus.dccm_wren}, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    send(1, 0, 2'd2, 16'h0100, 32'hDEADBEEF);
    check("ws_en", {bus.dccm_wren, bus.dccm_rden, bus.rsp_valid, bus.rsp_err}, 4'b1010);
    check("ws_addr", bus.dccm_wr_addr_lo, 16'h0100);
    check("ws_data", bus.dccm_wr_data_lo, 39'h00DEADBEEF);
    check("ws_busy", bus.req_ready, 0);
    step();
    check("ws_idle", {bus.req_ready, bus.rsp_valid, bus.dccm_wren}, 3'b100);
    send(0, 0, 2'd2, 16'h0100, 0);
    check("wl_rden", {bus.dccm_rden, bus.dccm_wren, bus.rsp_valid}, 3'b100);
    check("wl_addr", {bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, {16'h0100, 16'h0103});
    mem(32'hDEADBEEF, 32'hDEADBEEF);
    step();
    check("wl_rsp", {bus.rsp_valid, bus.rsp_err, bus.dccm_wren}, 3'b100);
    check("wl_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    step();
    send(1, 0, 2'd0, 16'h0102, 32'h0000005A);
    check("bs_rden", {bus.dccm_rden, bus.dccm_wren, bus.rsp_valid}, 3'b100);
    mem(32'h11223344, 32'h11223344);
    step();
    check("bs_wren", {bus.dccm_wren, bus.dccm_rden, bus.rsp_valid}, 3'b101);
    check("bs_data", bus.dccm_wr_data_lo, 39'h00115A3344);
    check("bs_addr", bus.dccm_wr_addr_lo, 16'h0102);
    step();
    check("bs_hold", bus.dccm_wr_data_lo, 39'h00115A3344);
    send(0, 0, 2'd2, 16'h0106, 0);
    check("ml_addr", {bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, {16'h0106, 16'h0109});
    mem(32'hAABBCCDD, 32'h11223344);
    step();
    check("ml_rdata", bus.rsp_rdata, 32'h3344AABB);
    step();
    send(0, 0, 2'd1, 16'h0002, 0);
    mem(32'h80FF0000, 32'h80FF0000);
    step();
    check("hl_signed", bus.rsp_rdata, 32'hFFFF80FF);
    step();
    send(0, 1, 2'd1, 16'h0002, 0);
    step();
    check("hl_unsigned", bus.rsp_rdata, 32'h000080FF);
    step();
    send(0, 0, 2'd3, 16'h0010, 0);
    check("err_rsp", {bus.rsp_valid, bus.rsp_err, bus.dccm_rden, bus.dccm_wren}, 4'b1100);
    step();
    check("err_done", {bus.req_ready, bus.rsp_valid, bus.rsp_err}, 3'b100);
    send(1, 0, 2'd1, 16'hFFFF, 32'h0000BEEF);
    check("wrap_rd", {bus.dccm_rden, bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, {1'b1, 16'hFFFF, 16'h0000});
    mem(32'h44332211, 32'h80FF0000);
    step();
    check("wrap_wren", {bus.dccm_wren, bus.rsp_valid}, 2'b11);
    check("wrap_addr", {bus.dccm_wr_addr_lo, bus.dccm_wr_addr_hi}, {16'hFFFF, 16'h0000});
    check("wrap_lo", bus.dccm_wr_data_lo, 39'h00EF332211);
    check("wrap_hi", bus.dccm_wr_data_hi, 39'h0080FF00BE);
    step();
    send(0, 0, 2'd0, 16'h0003, 0);
    mem(32'h80FF00BE, 32'h80FF00BE);
    step();
    check("bl_signed", bus.rsp_rdata, 32'hFFFFFF80);
    step();
    bus.req_valid = 1'b1;
    bus.req_store = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 16'h0200;
    step();
    check("bp_busy", {bus.req_ready, bus.dccm_rden}, 2'b01);
    bus.req_addr = 16'h0300;
    step();
    bus.req_valid = 1'b0;
    check("bp_rsp", bus.rsp_valid, 1);
    step();
    check("bp_ignored", {bus.req_ready, bus.dccm_rden, bus.rsp_valid}, 3'b100);
    send(1, 0, 2'd0, 16'h0100, 32'h000000A5);
    mem(32'h115A3344, 32'h115A3344);
    step();
    rst = 1'b1;
    #1;
    check("rm_gate", {bus.dccm_wren, bus.rsp_valid, bus.dccm_rden}, 0);
    step();
    rst = 1'b0;
    #1;
    check("rm_ready", {bus.req_ready, bus.rsp_valid, bus.dccm_wren}, 3'b100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
